pipelined_cpu16: RTL and testbench

16-bit, 5-stage (IF/ID/EX/MEM/WB) in-order pipelined processor core with 8 general registers and a 3-bit flag register. It has separate instruction and data ports to external memories with 8-bit addresses. It is the top compute block of the CPU lab design. There is no hazard detection, forwarding or flushing; software inserts NOPs.

---
 rtl/cpu16_pkg.sv | 60 ++++++
 rtl/cpu16_alu.sv | 58 +++++
 rtl/pipelined_cpu16.sv | 169 ++++++++++++++++
 tb/tb_pipelined_cpu16.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu16_pkg
//  Description : Opcode encodings, flag bit indices, controller state type and
//                instruction-class helpers shared by the 16-bit pipelined core.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu16_pkg;

  // 5-bit opcodes, instruction bits [15:11]
  localparam logic [4:0] NOP   = 5'b00000;
  localparam logic [4:0] HALT  = 5'b00001;
  localparam logic [4:0] LOAD  = 5'b00010;
  localparam logic [4:0] STORE = 5'b00011;
  localparam logic [4:0] SLL   = 5'b00100;
  localparam logic [4:0] SLA   = 5'b00101;
  localparam logic [4:0] SRL   = 5'b00110;
  localparam logic [4:0] SRA   = 5'b00111;
  localparam logic [4:0] ADD   = 5'b01000;
  localparam logic [4:0] ADDI  = 5'b01001;
  localparam logic [4:0] SUB   = 5'b01010;
  localparam logic [4:0] SUBI  = 5'b01011;
  localparam logic [4:0] CMP   = 5'b01100;
  localparam logic [4:0] AND   = 5'b01101;
  localparam logic [4:0] OR    = 5'b01110;
  localparam logic [4:0] XOR   = 5'b01111;
  localparam logic [4:0] LDIH  = 5'b10000;
  localparam logic [4:0] ADDC  = 5'b10001;
  localparam logic [4:0] SUBC  = 5'b10010;
  localparam logic [4:0] JUMP  = 5'b11000;
  localparam logic [4:0] JMPR  = 5'b11001;
  localparam logic [4:0] BZ    = 5'b11010;
  localparam logic [4:0] BNZ   = 5'b11011;
  localparam logic [4:0] BN    = 5'b11100;
  localparam logic [4:0] BNN   = 5'b11101;
  localparam logic [4:0] BC    = 5'b11110;
  localparam logic [4:0] BNC   = 5'b11111;

  // Flag register bit positions
  localparam int CF = 0;
  localparam int ZF = 1;
  localparam int NF = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  // Shifts, arithmetic/logic ops and LDIH: these update zf/nf
  function automatic logic is_alu(input logic [4:0] op);
    return ((op >= SLL) && (op <= XOR)) || ((op >= LDIH) && (op <= SUBC));
  endfunction

  // Instructions that write gr[r1] in WB
  function automatic logic writes_reg(input logic [4:0] op);
    return (is_alu(op) && (op != CMP)) || (op == LOAD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu16_alu.sv
`default_nettype none
// ============================================================================
//  Module      : cpu16_alu
//  Description : Combinational ALU for the EX stage. Carry-out is a real carry
//                for adds and a borrow for subtracts; other ops pass cf_in.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu16_alu
  import cpu16_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [15:0] reg_A,
  input  logic [15:0] reg_B,
  input  logic        cf_in,
  output logic [15:0] result,
  output logic        cf_out
);

  logic [16:0] wide;

  // Result and carry selection by opcode; address/target ops fall to the adder
  always_comb begin
    wide   = 17'd0;
    result = reg_A + reg_B;
    cf_out = cf_in;
    case (op)
      ADD, ADDI: begin
        wide   = {1'b0, reg_A} + {1'b0, reg_B};
        result = wide[15:0];
        cf_out = wide[16];
      end
      ADDC: begin
        wide   = {1'b0, reg_A} + {1'b0, reg_B} + {16'd0, cf_in};
        result = wide[15:0];
        cf_out = wide[16];
      end
      SUB, SUBI, CMP: begin
        wide   = {1'b0, reg_A} - {1'b0, reg_B};
        result = wide[15:0];
        cf_out = wide[16];
      end
      SUBC: begin
        wide   = {1'b0, reg_A} - {1'b0, reg_B} - {16'd0, cf_in};
        result = wide[15:0];
        cf_out = wide[16];
      end
      SLL, SLA: result = reg_A << reg_B[3:0];
      SRL:      result = reg_A >> reg_B[3:0];
      SRA:      result = $unsigned($signed(reg_A) >>> reg_B[3:0]);
      AND:      result = reg_A & reg_B;
      OR:       result = reg_A | reg_B;
      XOR:      result = reg_A ^ reg_B;
      default:  result = reg_A + reg_B;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_cpu16.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_cpu16
//  Description : 5-stage in-order 16-bit core, 8 GPRs, 3-bit flags. No hazard
//                detection, forwarding or flushing: software pads with NOPs.
//  Revision    : 1.0  initial release
// ============================================================================
module pipelined_cpu16
  import cpu16_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [15:0] i_datain,
  input  logic [15:0] d_datain,
  output logic [7:0]  i_addr,
  output logic [7:0]  d_addr,
  output logic [15:0] d_dataout,
  output logic        d_we
);

  state_t      state, state_next;
  logic [7:0]  pc;
  logic [15:0] id_ir, ex_ir, mem_ir, wb_ir;
  logic [15:0] reg_A, reg_B, reg_C, reg_C1;
  logic [15:0] smdr, smdr_mem;
  logic [15:0] gr [0:7];
  logic [2:0]  flag;

  logic [15:0] op_a, op_b, alu_result;
  logic        alu_cf, taken, advance;

  wire [4:0] id_op  = id_ir[15:11];
  wire [2:0] id_r1  = id_ir[10:8];
  wire [2:0] id_r2  = id_ir[6:4];
  wire [2:0] id_r3  = id_ir[2:0];
  wire [3:0] id_v3  = id_ir[3:0];
  wire [7:0] id_imm = id_ir[7:0];
  wire [4:0] ex_op  = ex_ir[15:11];
  wire [4:0] mem_op = mem_ir[15:11];
  wire [4:0] wb_op  = wb_ir[15:11];
  wire [2:0] wb_r1  = wb_ir[10:8];

  // Only opcode/r1 fields are needed past ID
  wire unused_ir_bits = ^{ex_ir[10:0], mem_ir[10:0], wb_ir[7:0]};

  assign advance   = enable && (state == S_EXEC);
  assign i_addr    = pc;
  assign d_addr    = reg_C[7:0];
  assign d_dataout = smdr_mem;
  assign d_we      = (mem_op == STORE) && (state == S_EXEC);

  cpu16_alu u_alu (
    .op     (ex_op),
    .reg_A  (reg_A),
    .reg_B  (reg_B),
    .cf_in  (flag[CF]),
    .result (alu_result),
    .cf_out (alu_cf)
  );

  // Controller state register; enable low freezes it
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       state <= S_IDLE;
    else if (enable) state <= state_next;
  end

  // Controller next state: start launches, HALT in WB stops
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_EXEC;
      S_EXEC:  if (wb_op == HALT) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ID operand selection by instruction class
  always_comb begin
    op_a = 16'h0000;
    op_b = 16'h0000;
    case (id_op)
      ADD, SUB, CMP, AND, OR, XOR, ADDC, SUBC: begin
        op_a = gr[id_r2];
        op_b = gr[id_r3];
      end
      ADDI, SUBI: begin
        op_a = gr[id_r1];
        op_b = {8'h00, id_imm};
      end
      LDIH: begin
        op_a = gr[id_r1];
        op_b = {id_imm, 8'h00};
      end
      SLL, SLA, SRL, SRA, LOAD, STORE: begin
        op_a = gr[id_r2];
        op_b = {12'h000, id_v3};
      end
      JUMP: op_b = {8'h00, id_imm};
      JMPR, BZ, BNZ, BN, BNN, BC, BNC: begin
        op_a = gr[id_r1];
        op_b = {8'h00, id_imm};
      end
      default: ;
    endcase
  end

  // Branch decision from the instruction in MEM against the current flags
  always_comb begin
    taken = 1'b0;
    case (mem_op)
      JUMP, JMPR: taken = 1'b1;
      BZ:         taken = flag[ZF];
      BNZ:        taken = !flag[ZF];
      BN:         taken = flag[NF];
      BNN:        taken = !flag[NF];
      BC:         taken = flag[CF];
      BNC:        taken = !flag[CF];
      default:    taken = 1'b0;
    endcase
  end

  // Pipeline registers, pc and flags advance together only while executing
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= 8'h00;
      id_ir    <= 16'h0000;
      ex_ir    <= 16'h0000;
      mem_ir   <= 16'h0000;
      wb_ir    <= 16'h0000;
      reg_A    <= 16'h0000;
      reg_B    <= 16'h0000;
      reg_C    <= 16'h0000;
      reg_C1   <= 16'h0000;
      smdr     <= 16'h0000;
      smdr_mem <= 16'h0000;
      flag     <= 3'b000;
    end else if (advance) begin
      pc       <= taken ? reg_C[7:0] : pc + 8'd1;
      id_ir    <= i_datain;
      ex_ir    <= id_ir;
      smdr     <= gr[id_r1];
      reg_A    <= op_a;
      reg_B    <= op_b;
      mem_ir   <= ex_ir;
      reg_C    <= alu_result;
      smdr_mem <= smdr;
      wb_ir    <= mem_ir;
      reg_C1   <= (mem_op == LOAD) ? d_datain : reg_C;
      if (is_alu(ex_op)) begin
        flag[ZF] <= (alu_result == 16'h0000);
        flag[NF] <= alu_result[15];
        flag[CF] <= alu_cf;
      end
    end
  end

  // Register file write-back; no bypass to the same-cycle ID read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) gr[i] <= 16'h0000;
    end else if (advance && writes_reg(wb_op)) begin
      gr[wb_r1] <= reg_C1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cpu16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_cpu16
//  Description : Directed self-checking bench for pipelined_cpu16.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_cpu16;
  import cpu16_pkg::*;

  logic        clock, reset, enable, start;
  logic [15:0] i_datain, d_datain, d_dataout;
  logic [7:0]  i_addr, d_addr;
  logic        d_we;

  logic [15:0] imem [0:255];
  logic [7:0]  st_addr;
  logic [15:0] st_data;
  int          st_count;

  int checks = 0;
  int errors = 0;

  localparam int W_EX  = 0;
  localparam int W_MEM = 1;
  localparam int W_WB  = 2;

  pipelined_cpu16 dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .i_datain  (i_datain),
    .d_datain  (d_datain),
    .i_addr    (i_addr),
    .d_addr    (d_addr),
    .d_dataout (d_dataout),
    .d_we      (d_we)
  );

  assign i_datain = imem[i_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Store capture
  always @(posedge clock) begin
    if (reset) st_count <= 0;
    else if (d_we) begin
      st_addr  <= d_addr;
      st_data  <= d_dataout;
      st_count <= st_count + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    enable = 1'b1;
    start  = 1'b0;
    reset  = 1'b1;
    step();
    reset  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_ir(input int which, input logic [15:0] ir, input string tag);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      case (which)
        W_EX:    found = (dut.ex_ir == ir);
        W_MEM:   found = (dut.mem_ir == ir);
        default: found = (dut.wb_ir == ir);
      endcase
      if (!found) step();
    end
    check(tag, {15'd0, found}, 16'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      found = (dut.state == S_IDLE);
      if (!found) step();
    end
    check(tag, {15'd0, found}, 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    enable   = 1'b0;
    start    = 1'b0;
    reset    = 1'b0;
    d_datain = 16'h0000;
    clear_imem();
    #2;

    // ---------------- reset / start with NOPs ----------------
    do_reset();
    check("rst_pc", {8'h00, i_addr}, 16'h0000);
    check("rst_dwe", {15'd0, d_we}, 16'h0000);
    check("rst_daddr", {8'h00, d_addr}, 16'h0000);
    check("rst_dout", d_dataout, 16'h0000);
    check("rst_flag", {13'd0, dut.flag}, 16'h0000);
    for (int i = 0; i < 8; i++) check($sformatf("rst_gr%0d", i), dut.gr[i], 16'h0000);
    step(); step(); step();
    check("idle_pc_hold", {8'h00, dut.pc}, 16'h0000);
    pulse_start();
    check("start_pc0", {8'h00, dut.pc}, 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("pc_inc%0d", k), {8'h00, i_addr}, k[15:0]);
      check("nop_dwe", {15'd0, d_we}, 16'h0000);
    end

    // ---------------- BNZ taken ----------------
    clear_imem();
    imem[0]     = 16'h4902;  // ADDI r1, 0x02
    imem[4]     = 16'hD921;  // BNZ  r1, 0x21 -> 2 + 0x21 = 0x23
    imem[8]     = 16'h0800;  // HALT (skipped)
    imem[8'h23] = 16'h0800;  // HALT at target
    do_reset();
    pulse_start();
    wait_ir(W_MEM, 16'hD921, "bnz_reach_mem");
    check("bnz_regC", dut.reg_C, 16'h0023);
    check("bnz_pc_before", {8'h00, dut.pc}, 16'h0007);
    step();
    check("bnz_pc_target", {8'h00, dut.pc}, 16'h0023);
    wait_idle("bnz_idle");
    check("bnz_pc_final", {8'h00, dut.pc}, 16'h0028);
    check("bnz_gr1", dut.gr[1], 16'h0002);

    // ---------------- BZ not taken ----------------
    imem[4] = 16'hD121;      // BZ r1, 0x21
    do_reset();
    pulse_start();
    wait_ir(W_MEM, 16'hD121, "bz_reach_mem");
    check("bz_pc_before", {8'h00, dut.pc}, 16'h0007);
    step();
    check("bz_pc_seq", {8'h00, dut.pc}, 16'h0008);
    wait_idle("bz_idle");
    check("bz_pc_final", {8'h00, dut.pc}, 16'h000D);
    step(); step(); step();
    check("bz_pc_hold", {8'h00, dut.pc}, 16'h000D);
    check("bz_state", 16'(dut.state), 16'(S_IDLE));

    // ---------------- ADDI, CMP, SUBI borrow ----------------
    clear_imem();
    imem[0]  = 16'h4A01;     // ADDI r2, 0x01
    imem[4]  = 16'h4AFF;     // ADDI r2, 0xFF -> 0x0100
    imem[8]  = 16'h6022;     // CMP  r2, r2
    imem[12] = 16'h5C01;     // SUBI r4, 0x01 -> 0xFFFF, borrow
    imem[16] = 16'h0800;     // HALT
    do_reset();
    pulse_start();
    wait_ir(W_MEM, 16'h4AFF, "addi_reach_mem");
    check("addi_regC", dut.reg_C, 16'h0100);
    check("addi_flags", {13'd0, dut.flag}, 16'h0000);
    wait_ir(W_MEM, 16'h6022, "cmp_reach_mem");
    check("cmp_flags", {13'd0, dut.flag}, 16'h0002);
    wait_idle("alu_idle");
    check("addi_gr2", dut.gr[2], 16'h0100);
    check("cmp_no_wr_gr0", dut.gr[0], 16'h0000);
    check("subi_gr4", dut.gr[4], 16'hFFFF);
    check("subi_flags", {13'd0, dut.flag}, 16'h0005);

    // ---------------- STORE / LOAD ----------------
    clear_imem();
    imem[0]  = 16'h49EF;     // ADDI  r1, 0xEF
    imem[1]  = 16'h4A10;     // ADDI  r2, 0x10
    imem[4]  = 16'h81BE;     // LDIH  r1, 0xBE -> 0xBEEF
    imem[8]  = 16'h1923;     // STORE r1, r2, 3 -> [0x13]
    imem[9]  = 16'h1324;     // LOAD  r3, r2, 4 <- [0x14]
    imem[13] = 16'h0800;     // HALT
    d_datain = 16'h1234;
    do_reset();
    pulse_start();
    wait_ir(W_MEM, 16'h1923, "store_reach_mem");
    check("st_dwe", {15'd0, d_we}, 16'h0001);
    check("st_daddr", {8'h00, d_addr}, 16'h0013);
    check("st_dout", d_dataout, 16'hBEEF);
    step();
    check("ld_dwe", {15'd0, d_we}, 16'h0000);
    check("ld_daddr", {8'h00, d_addr}, 16'h0014);
    wait_idle("mem_idle");
    check("st_count", st_count[15:0], 16'h0001);
    check("st_addr_cap", {8'h00, st_addr}, 16'h0013);
    check("st_data_cap", st_data, 16'hBEEF);
    check("ldih_gr1", dut.gr[1], 16'hBEEF);
    check("load_gr3", dut.gr[3], 16'h1234);
    d_datain = 16'h0000;

    // ---------------- enable freeze ----------------
    clear_imem();
    imem[0] = 16'h4D07;      // ADDI r5, 0x07
    imem[4] = 16'h4D01;      // ADDI r5, 0x01 -> 0x0008
    imem[8] = 16'h0800;      // HALT
    do_reset();
    pulse_start();
    step(); step();
    enable = 1'b0;
    step(); step(); step(); step(); step();
    check("frz_pc", {8'h00, dut.pc}, 16'h0002);
    check("frz_ex_ir", dut.ex_ir, 16'h4D07);
    check("frz_regB", dut.reg_B, 16'h0007);
    check("frz_mem_ir", dut.mem_ir, 16'h0000);
    check("frz_gr5", dut.gr[5], 16'h0000);
    enable = 1'b1;
    step();
    check("resume_pc", {8'h00, dut.pc}, 16'h0003);
    check("resume_mem_ir", dut.mem_ir, 16'h4D07);
    wait_idle("frz_idle");
    check("frz_final_gr5", dut.gr[5], 16'h0008);

    // ---------------- asynchronous reset mid-run ----------------
    clear_imem();
    do_reset();
    pulse_start();
    step(); step(); step(); step();
    check("pre_areset_pc", {8'h00, dut.pc}, 16'h0004);
    #3;
    reset = 1'b1;
    #1;
    check("areset_pc", {8'h00, dut.pc}, 16'h0000);
    check("areset_state", 16'(dut.state), 16'(S_IDLE));
    reset = 1'b0;
    step();
    check("areset_hold", {8'h00, dut.pc}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
